// File: rtl/simd_shift_sequencer.sv
// rtl/simd_shift_sequencer.sv - iterates a one-bit lane-masked shift in_amt times behind valid/ready ports.
// Optional per-lane arithmetic right shift is enabled by defining SIMD_SEQ_ARITH_EN.
module simd_shift_sequencer #(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   input  logic             in_left,
   input  logic [AMT_W-1:0] in_amt,
   input  logic             in_arith,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       mode_q, mode_d;
   logic             left_q, left_d;
   logic             arith_q, arith_d;

   logic [WIDTH-1:0] msb_mask, lsb_mask, fill, step;

   // Lane boundary masks; mode 11 falls through to the single 16-bit lane.
   always_comb begin
      msb_mask = 16'h8000;
      lsb_mask = 16'h0001;
      case (mode_q)
         2'b00: begin msb_mask = 16'h8888; lsb_mask = 16'h1111; end
         2'b01: begin msb_mask = 16'h8080; lsb_mask = 16'h0101; end
         default: ;
      endcase
   end

`ifdef SIMD_SEQ_ARITH_EN
   assign fill = arith_q ? (data_q & msb_mask) : '0;
`else
   logic unused_arith;
   assign unused_arith = arith_q;
   assign fill = '0;
`endif

   always_comb begin
      if (left_q) step = {data_q[WIDTH-2:0], 1'b0} & ~lsb_mask;
      else        step = ({1'b0, data_q[WIDTH-1:1]} & ~msb_mask) | fill;
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      left_d  = left_q;
      arith_d = arith_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               data_d  = in_data;
               cnt_d   = in_amt;
               mode_d  = in_mode;
               left_d  = in_left;
               arith_d = in_arith;
               state_d = (in_amt != '0) ? S_SHIFT : S_DONE;
            end
         end
         S_SHIFT: begin
            data_d = step;
            cnt_d  = cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         mode_q  <= 2'b00;
         left_q  <= 1'b0;
         arith_q <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         left_q  <= left_d;
         arith_q <= arith_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign out_data  = data_q;

   logic unused_in_arith;
   assign unused_in_arith = in_arith;

endmodule
